// File: rtl/noc_pkg.sv
// Shared flit-format constants and FSM state type for the NoC send-side network interface.
package noc_pkg;

  localparam int FLIT_DATA_WIDTH = 64;
  localparam int DEST_BITS       = 4;
  localparam int VC_BITS         = 1;
  localparam int NUM_VCS         = 2;
  localparam int NUM_RECV_PORTS  = 9;

  // Flit layout, MSB first: {valid, tail, dest, vc, data}
  localparam int FLIT_W    = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
  localparam int CREDIT_W  = 1 + VC_BITS;
  localparam int VALID_BIT = FLIT_W - 1;
  localparam int TAIL_BIT  = FLIT_W - 2;
  localparam int DEST_LSB  = VC_BITS + FLIT_DATA_WIDTH;
  localparam int VC_LSB    = FLIT_DATA_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/noc_credit_counter.sv
// Per-VC credit counter: starts full, saturates on over-return and flags it with a one-cycle pulse.
module noc_credit_counter #(
  parameter int BUF_DEPTH = 4
) (
  input  logic Clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic has_credit,
  output logic overflow
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    has_credit = (cnt != '0);
    // A return that coincides with a send cancels out, so it can never overflow.
    overflow   = inc && !dec && (cnt == FULL);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt <= FULL;
    end else if (inc && !dec) begin
      if (cnt != FULL) cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/noc_send_ni.sv
// Injection network interface: serializes one request packet into head/body/tail flits under per-VC credits.
module noc_send_ni
  import noc_pkg::*;
#(
  parameter int PKT_FLITS = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                                 Clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [DEST_BITS-1:0]                 req_dest,
  input  logic [VC_BITS-1:0]                   req_vc,
  input  logic [PKT_FLITS*FLIT_DATA_WIDTH-1:0] req_data,
  output logic [FLIT_W-1:0]                    flit_out,
  output logic                                 flit_en,
  input  logic [CREDIT_W-1:0]                  credit_in,
  output logic                                 credit_drain,
  output logic                                 credit_err,
  output logic [31:0]                          pkt_count
);

  localparam int IDX_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_FLITS - 1);

  state_t                               state, state_nxt;
  logic [IDX_W-1:0]                     idx;
  logic [DEST_BITS-1:0]                 dest_l;
  logic [VC_BITS-1:0]                   vc_l;
  logic [PKT_FLITS*FLIT_DATA_WIDTH-1:0] data_l;

  logic [NUM_VCS-1:0] has_credit, ovf, inc, dec;
  logic               credit_valid, credit_bad, vc_ok, cur_credit, is_tail, fire, accept;
  logic [VC_BITS-1:0] credit_vc;

  assign credit_valid = credit_in[CREDIT_W-1];
  assign credit_vc    = credit_in[VC_BITS-1:0];
  assign credit_bad   = credit_valid && (int'(credit_vc) >= NUM_VCS);
  assign vc_ok        = int'(vc_l) < NUM_VCS;
  assign cur_credit   = vc_ok && has_credit[vc_l];
  assign is_tail      = (idx == LAST_IDX);
  // Send decision uses only registered state and counts; credit_in lands at the edge.
  assign fire         = !reset && (state == SEND) && cur_credit;
  assign accept       = req_ready && req_valid;
  assign credit_drain = !reset;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign inc[v] = credit_valid && (credit_vc == VC_BITS'(v));
    assign dec[v] = fire && (vc_l == VC_BITS'(v));

    noc_credit_counter #(
      .BUF_DEPTH (BUF_DEPTH)
    ) u_credit (
      .Clk        (Clk),
      .reset      (reset),
      .inc        (inc[v]),
      .dec        (dec[v]),
      .has_credit (has_credit[v]),
      .overflow   (ovf[v])
    );
  end

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    flit_en   = 1'b0;
    flit_out  = '0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) state_nxt = SEND;
      end
      SEND: begin
        if (fire) begin
          flit_en  = 1'b1;
          flit_out = {1'b1, is_tail, dest_l, vc_l,
                      data_l[FLIT_DATA_WIDTH*int'(idx) +: FLIT_DATA_WIDTH]};
          if (is_tail) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      idx        <= '0;
      credit_err <= 1'b0;
      pkt_count  <= '0;
    end else begin
      if (accept) begin
        idx <= '0;
      end else if (fire) begin
        idx <= is_tail ? '0 : idx + IDX_W'(1);
        if (is_tail) pkt_count <= pkt_count + 32'd1;
      end
      if ((|ovf) || credit_bad) credit_err <= 1'b1;
    end
  end

  // Packet payload is held only while the packet is in flight; no reset needed.
  always_ff @(posedge Clk) begin
    if (accept) begin
      dest_l <= req_dest;
      vc_l   <= req_vc;
      data_l <= req_data;
    end
  end

endmodule
